// File: rtl/data_cache_if.sv
// CPU request/completion and backing-memory channels of the direct-mapped data cache.
// master = CPU/memory side, slave = cache side.
interface data_cache_if;
   logic         is_input_valid;
   logic [31:0]  addr;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  din;
   logic         is_ready;
   logic         is_output_valid;
   logic [31:0]  dout;
   logic         is_hit;
   logic         mem_req_valid;
   logic         mem_req_write;
   logic [31:0]  mem_req_addr;
   logic [127:0] mem_req_line;
   logic         mem_req_ready;
   logic         mem_resp_valid;
   logic [127:0] mem_resp_line;

   modport master (
      output is_input_valid, addr, mem_read, mem_write, din,
      output mem_req_ready, mem_resp_valid, mem_resp_line,
      input  is_ready, is_output_valid, dout, is_hit,
      input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_line
   );

   modport slave (
      input  is_input_valid, addr, mem_read, mem_write, din,
      input  mem_req_ready, mem_resp_valid, mem_resp_line,
      output is_ready, is_output_valid, dout, is_hit,
      output mem_req_valid, mem_req_write, mem_req_addr, mem_req_line
   );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped write-back data cache, 16-byte lines, blocking on misses.
// The lookup is evaluated on the incoming address at acceptance so completion outputs are registered.
module data_cache #(
   parameter int NUM_SETS   = 16,
   parameter int LINE_WORDS = 4
) (
   input logic         clk,
   input logic         reset,
   data_cache_if.slave bus
);
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = 28 - IDX_W;
   localparam int LINE_W = 32 * LINE_WORDS;

   typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_e;

   typedef struct packed {
      logic             store;
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] idx;
      logic [1:0]       off;
      logic [31:0]      din;
   } req_t;

   state_e              state_q, state_d;
   req_t                req_q, req_d;
   logic                hit_q, hit_d;
   logic                wait_q, wait_d;
   logic                out_valid_q, out_valid_d;
   logic                is_hit_q, is_hit_d;
   logic [31:0]         dout_q, dout_d;
   logic                mreq_valid_q, mreq_valid_d;
   logic                mreq_write_q, mreq_write_d;
   logic [31:0]         mreq_addr_q, mreq_addr_d;
   logic [LINE_W-1:0]   mreq_line_q, mreq_line_d;
   logic [NUM_SETS-1:0] valid_q, valid_d;
   logic [NUM_SETS-1:0] dirty_q, dirty_d;
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   logic [TAG_W-1:0]    tag_d  [NUM_SETS];
   logic [LINE_W-1:0]   data_q [NUM_SETS];
   logic [LINE_W-1:0]   data_d [NUM_SETS];
   logic [31:0]         hit_count, hit_count_d;
   logic [31:0]         miss_count, miss_count_d;

   logic [IDX_W-1:0] a_idx;
   logic [TAG_W-1:0] a_tag;
   logic [1:0]       a_off;
   logic             a_hit;
   logic             accept;
   logic [31:0]      a_word;
   logic [31:0]      fill_word;
   logic             unused_addr;

   assign a_idx       = bus.addr[IDX_W+3:4];
   assign a_tag       = bus.addr[31:IDX_W+4];
   assign a_off       = bus.addr[3:2];
   assign a_hit       = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
   assign a_word      = data_q[a_idx][32*a_off +: 32];
   assign fill_word   = bus.mem_resp_line[32*req_q.off +: 32];
   assign accept      = (state_q == IDLE) && bus.is_input_valid && (bus.mem_read || bus.mem_write);
   assign unused_addr = ^bus.addr[1:0];

   assign bus.is_ready        = (state_q == IDLE);
   assign bus.is_output_valid = out_valid_q;
   assign bus.is_hit          = is_hit_q;
   assign bus.dout            = dout_q;
   assign bus.mem_req_valid   = mreq_valid_q;
   assign bus.mem_req_write   = mreq_write_q;
   assign bus.mem_req_addr    = mreq_addr_q;
   assign bus.mem_req_line    = mreq_line_q;

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      hit_d        = hit_q;
      wait_d       = wait_q;
      out_valid_d  = 1'b0;
      is_hit_d     = 1'b0;
      dout_d       = dout_q;
      mreq_valid_d = mreq_valid_q;
      mreq_write_d = mreq_write_q;
      mreq_addr_d  = mreq_addr_q;
      mreq_line_d  = mreq_line_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      tag_d        = tag_q;
      data_d       = data_q;
      hit_count_d  = hit_count;
      miss_count_d = miss_count;
      case (state_q)
         IDLE: begin
            if (accept) begin
               // read+write together is a store
               req_d = '{store: bus.mem_write, tag: a_tag, idx: a_idx, off: a_off, din: bus.din};
               hit_d   = a_hit;
               state_d = COMPARE;
               if (a_hit) begin
                  out_valid_d = 1'b1;
                  is_hit_d    = 1'b1;
                  dout_d      = bus.mem_write ? bus.din : a_word;
                  hit_count_d = hit_count + 32'd1;
               end else begin
                  miss_count_d = miss_count + 32'd1;
               end
            end
         end
         COMPARE: begin
            if (hit_q) begin
               state_d = IDLE;
               if (req_q.store) begin
                  data_d[req_q.idx][32*req_q.off +: 32] = req_q.din;
                  dirty_d[req_q.idx] = 1'b1;
               end
            end else begin
               mreq_valid_d = 1'b1;
               wait_d       = 1'b0;
               if (valid_q[req_q.idx] && dirty_q[req_q.idx]) begin
                  state_d      = WRITE_BACK;
                  mreq_write_d = 1'b1;
                  mreq_addr_d  = {tag_q[req_q.idx], req_q.idx, 4'b0};
                  mreq_line_d  = data_q[req_q.idx];
               end else begin
                  state_d      = ALLOCATE;
                  mreq_write_d = 1'b0;
                  mreq_addr_d  = {req_q.tag, req_q.idx, 4'b0};
               end
            end
         end
         WRITE_BACK: begin
            if (mreq_valid_q) begin
               if (bus.mem_req_ready) begin
                  mreq_valid_d = 1'b0;
                  wait_d       = 1'b1;
               end
            end else if (wait_q && bus.mem_resp_valid) begin
               dirty_d[req_q.idx] = 1'b0;
               wait_d       = 1'b0;
               state_d      = ALLOCATE;
               mreq_valid_d = 1'b1;
               mreq_write_d = 1'b0;
               mreq_addr_d  = {req_q.tag, req_q.idx, 4'b0};
            end
         end
         ALLOCATE: begin
            if (mreq_valid_q) begin
               if (bus.mem_req_ready) begin
                  mreq_valid_d = 1'b0;
                  wait_d       = 1'b1;
               end
            end else if (wait_q && bus.mem_resp_valid) begin
               // the retried lookup is known to hit, so its completion is produced here
               valid_d[req_q.idx] = 1'b1;
               dirty_d[req_q.idx] = 1'b0;
               tag_d[req_q.idx]   = req_q.tag;
               data_d[req_q.idx]  = bus.mem_resp_line;
               wait_d      = 1'b0;
               state_d     = COMPARE;
               hit_d       = 1'b1;
               out_valid_d = 1'b1;
               dout_d      = req_q.store ? req_q.din : fill_word;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         hit_q        <= 1'b0;
         wait_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         is_hit_q     <= 1'b0;
         dout_q       <= '0;
         mreq_valid_q <= 1'b0;
         mreq_write_q <= 1'b0;
         mreq_addr_q  <= '0;
         mreq_line_q  <= '0;
         valid_q      <= '0;
         dirty_q      <= '0;
         hit_count    <= '0;
         miss_count   <= '0;
      end else begin
         state_q      <= state_d;
         hit_q        <= hit_d;
         wait_q       <= wait_d;
         out_valid_q  <= out_valid_d;
         is_hit_q     <= is_hit_d;
         dout_q       <= dout_d;
         mreq_valid_q <= mreq_valid_d;
         mreq_write_q <= mreq_write_d;
         mreq_addr_q  <= mreq_addr_d;
         mreq_line_q  <= mreq_line_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         hit_count    <= hit_count_d;
         miss_count   <= miss_count_d;
      end
      req_q  <= req_d;
      tag_q  <= tag_d;
      data_q <= data_d;
   end
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: CPU-side tasks plus a backing-memory responder with
// programmable ready stall and response delay.
module tb_data_cache;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   data_cache_if bus ();
   data_cache #(.NUM_SETS(16), .LINE_WORDS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // backing memory: lines not yet written read back as word k = line_addr + 4k
   logic [127:0] mem [logic [31:0]];
   logic [31:0]  log_addr [$];
   logic         log_wr   [$];
   logic [127:0] log_line [$];
   int           stall = 0;
   int           resp_delay = 2;
   int           resp_cnt = 0;
   logic [31:0]  cap_addr;
   logic         cap_wr;
   logic [127:0] cap_line;

   function automatic logic [127:0] mem_line(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a + 32'd12, a + 32'd8, a + 32'd4, a};
   endfunction

   initial begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_line  = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_resp_valid = 1'b0;
         if (bus.mem_req_ready) begin
            log_addr.push_back(cap_addr);
            log_wr.push_back(cap_wr);
            log_line.push_back(cap_line);
            if (cap_wr) mem[cap_addr] = cap_line;
            resp_cnt = resp_delay;
            bus.mem_req_ready = 1'b0;
         end else if (bus.mem_req_valid) begin
            if (stall > 0) stall--;
            else begin
               cap_addr = bus.mem_req_addr;
               cap_wr   = bus.mem_req_write;
               cap_line = bus.mem_req_line;
               bus.mem_req_ready = 1'b1;
            end
         end
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               bus.mem_resp_valid = 1'b1;
               bus.mem_resp_line  = cap_wr ? 128'h0 : mem_line(cap_addr);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic cpu_issue(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
      int t = 0;
      @(negedge clk);
      while (!bus.is_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", bus.is_ready, 1'b1);
      bus.addr = a;
      bus.mem_read = rd;
      bus.mem_write = wr;
      bus.din = d;
      bus.is_input_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.is_input_valid = 1'b0;
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   task automatic wait_done(output logic [31:0] d, output logic h, output int lat);
      logic done = 1'b0;
      lat = 0;
      d = '0;
      h = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (bus.is_output_valid) begin
            d = bus.dout;
            h = bus.is_hit;
            lat = i;
            done = 1'b1;
            break;
         end
      end
      chk("done_wait", done, 1'b1);
   endtask

   task automatic cpu_acc(input string tag, input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] d, input logic [31:0] exp_d, input logic exp_h);
      logic [31:0] got_d;
      logic        got_h;
      int          lat;
      cpu_issue(a, rd, wr, d);
      wait_done(got_d, got_h, lat);
      chk({tag, "_dout"}, got_d, exp_d);
      chk({tag, "_hit"}, got_h, exp_h);
      if (exp_h) chk({tag, "_lat"}, lat, 1);
   endtask

   logic [31:0] t_addr [13];
   logic [31:0] t_exp  [13];
   logic        t_hit  [13];
   logic        ok;
   int          pulses;
   int          n0;

   initial begin
      reset = 1'b1;
      bus.is_input_valid = 1'b0;
      bus.addr = '0;
      bus.mem_read = 1'b0;
      bus.mem_write = 1'b0;
      bus.din = '0;
      mem[32'h100] = {32'hCAFE0003, 32'hCAFE0002, 32'hDEADBEEF, 32'hCAFE0000};

      do_reset();
      chk("rst_ready", bus.is_ready, 1'b1);
      chk("rst_ovalid", bus.is_output_valid, 1'b0);
      chk("rst_hit", bus.is_hit, 1'b0);
      chk("rst_dout", bus.dout, 32'h0);
      chk("rst_mreq", bus.mem_req_valid, 1'b0);
      chk("rst_hitcnt", dut.hit_count, 32'd0);
      chk("rst_misscnt", dut.miss_count, 32'd0);

      // cold fill, then a hit on the neighbouring word
      cpu_acc("cold", 32'h100, 1, 0, 0, 32'hCAFE0000, 0);
      chk("cold_nreq", log_addr.size(), 1);
      chk("cold_raddr", log_addr[0], 32'h100);
      chk("cold_rwr", log_wr[0], 1'b0);
      cpu_acc("hit104", 32'h104, 1, 0, 0, 32'hDEADBEEF, 1);

      // dirty victim goes out before the conflicting line comes in
      cpu_acc("st104", 32'h104, 0, 1, 32'h12345678, 32'h12345678, 1);
      cpu_acc("ld204", 32'h204, 1, 0, 0, 32'h204, 0);
      chk("wb_nreq", log_addr.size(), 3);
      chk("wb_addr", log_addr[1], 32'h100);
      chk("wb_wr", log_wr[1], 1'b1);
      chk("wb_word1", log_line[1][63:32], 32'h12345678);
      chk("wb_line", log_line[1], {32'hCAFE0003, 32'hCAFE0002, 32'h12345678, 32'hCAFE0000});
      chk("al_addr", log_addr[2], 32'h200);
      chk("al_wr", log_wr[2], 1'b0);
      chk("cnt_hit2", dut.hit_count, 32'd2);
      chk("cnt_miss2", dut.miss_count, 32'd2);
      cpu_acc("reld104", 32'h104, 1, 0, 0, 32'h12345678, 0);

      // memory holds off ready for 5 cycles
      stall = 5;
      cpu_issue(32'h30C, 1, 0, 0);
      for (int i = 0; i < 20 && !bus.mem_req_valid; i++) @(negedge clk);
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (!bus.mem_req_valid || bus.mem_req_addr !== 32'h300 || bus.mem_req_write !== 1'b0 ||
             bus.is_ready || bus.mem_req_ready) ok = 1'b0;
         @(negedge clk);
      end
      chk("stall_stable", ok, 1'b1);
      chk("stall_rdy", bus.mem_req_ready, 1'b1);
      chk("stall_vld", bus.mem_req_valid, 1'b1);
      @(negedge clk);
      chk("vld_fall", bus.mem_req_valid, 1'b0);
      begin
         logic [31:0] gd; logic gh; int gl;
         wait_done(gd, gh, gl);
         chk("stall_dout", gd, 32'h30C);
         chk("stall_hit", gh, 1'b0);
      end
      chk("stall_addr", log_addr[log_addr.size()-1], 32'h300);

      // reset while the request is still being offered
      stall = 10;
      cpu_issue(32'h500, 1, 0, 0);
      for (int i = 0; i < 20 && !bus.mem_req_valid; i++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid_vld", bus.mem_req_valid, 1'b0);
      chk("rstmid_rdy", bus.is_ready, 1'b1);
      reset = 1'b0;
      stall = 0;

      // reset while waiting for the fill; the late response must be dropped
      resp_delay = 5;
      cpu_issue(32'h504, 1, 0, 0);
      n0 = log_addr.size();
      for (int i = 0; i < 30 && log_addr.size() == n0; i++) @(negedge clk);
      chk("alw_sent", log_addr.size(), n0 + 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ok = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (!bus.is_ready || bus.is_output_valid || bus.mem_req_valid) ok = 1'b0;
         @(negedge clk);
      end
      chk("spur_idle", ok, 1'b1);
      resp_delay = 2;
      chk("spur_misscnt0", dut.miss_count, 32'd0);
      cpu_acc("after_rst", 32'h504, 1, 0, 0, 32'h504, 0);
      chk("spur_misscnt1", dut.miss_count, 32'd1);
      chk("spur_hitcnt0", dut.hit_count, 32'd0);

      // read+write together behaves as a store
      cpu_acc("rdwr", 32'h508, 1, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1);
      cpu_acc("rdwr_chk", 32'h508, 1, 0, 0, 32'hA5A5A5A5, 1);
      cpu_acc("other_word", 32'h50C, 1, 0, 0, 32'h50C, 1);

      // a request held high hits once every two cycles
      @(negedge clk);
      bus.addr = 32'h500;
      bus.mem_read = 1'b1;
      bus.is_input_valid = 1'b1;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.is_output_valid) pulses++;
      end
      bus.is_input_valid = 1'b0;
      bus.mem_read = 1'b0;
      chk("b2b_pulses", pulses, 3);

      // neither read nor write: never accepted
      bus.is_input_valid = 1'b1;
      ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (!bus.is_ready || bus.is_output_valid || bus.mem_req_valid) ok = 1'b0;
      end
      bus.is_input_valid = 1'b0;
      chk("noop_idle", ok, 1'b1);
      chk("noop_hitcnt", dut.hit_count, 32'd6);
      chk("noop_misscnt", dut.miss_count, 32'd1);

      // ten hits interleaved with three misses
      do_reset();
      t_addr = '{32'h600, 32'h600, 32'h604, 32'h608, 32'h60C, 32'h610, 32'h614,
                 32'h618, 32'h61C, 32'h620, 32'h620, 32'h624, 32'h628};
      t_exp  = '{32'h600, 32'h600, 32'h604, 32'h608, 32'h60C, 32'h610, 32'h614,
                 32'h618, 32'h11, 32'h620, 32'h620, 32'h624, 32'h628};
      t_hit  = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
      for (int i = 0; i < 13; i++)
         cpu_acc($sformatf("mix%0d", i), t_addr[i], (i != 8), (i == 8), 32'h11, t_exp[i], t_hit[i]);
      chk("mix_hitcnt", dut.hit_count, 32'd10);
      chk("mix_misscnt", dut.miss_count, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter NUM_SETS, default 16, meaning number of direct-mapped lines; the block SHALL support powers of two from 4 to 256.
REQ-002 Parameter LINE_WORDS, default 4, meaning 32-bit words per line; the block SHALL support only the value 4 (16-byte line).
REQ-003 Port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, meaning synchronous active-high reset.
REQ-005 Port is_input_valid, input, 1, meaning CPU presents a request this cycle.
REQ-006 Port addr, input, 32, meaning byte address; bits [1:0] are ignored.
REQ-007 Port mem_read, input, 1, meaning the request is a load.
REQ-008 Port mem_write, input, 1, meaning the request is a store.
REQ-009 Port din, input, 32, meaning store data.
REQ-010 Port is_ready, output, 1, meaning a request can be accepted this cycle.
REQ-011 Port is_output_valid, output, 1, meaning a one-cycle completion pulse.
REQ-012 Port dout, output, 32, meaning load data, or store data echoed on a store.
REQ-013 Port is_hit, output, 1, meaning the completing access hit on its first lookup.
REQ-014 Ports mem_req_valid (output, 1), mem_req_write (output, 1), mem_req_addr (output, 32, line-aligned), mem_req_line (output, 128), mem_req_ready (input, 1), meaning the backing-memory request channel.
REQ-015 Ports mem_resp_valid (input, 1) and mem_resp_line (input, 128), meaning the backing-memory response channel; a write receives a response with don't-care data.

Function
REQ-016 The address split SHALL be word offset addr[3:2], index addr[4+log2(NUM_SETS)-1:4], and tag as the remaining upper bits.
REQ-017 Each line SHALL hold valid, dirty, tag and 128 data bits, with word k at bits [32k+31:32k].
REQ-018 The FSM SHALL use states IDLE, COMPARE, WRITE_BACK and ALLOCATE.
REQ-019 is_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted at a rising edge where is_ready=1, is_input_valid=1 and (mem_read or mem_write)=1; addr, din and type SHALL then be latched.
REQ-021 A request with both mem_read and mem_write set SHALL be treated as a store; a request with neither set SHALL NOT be accepted.
REQ-022 Accepted transition: IDLE -> COMPARE.
REQ-023 COMPARE hit (valid and tag match): the block SHALL pulse is_output_valid=1 in that cycle and go to IDLE.
REQ-024 On a COMPARE hit for a load, dout SHALL be the addressed word.
REQ-025 On a COMPARE hit for a store, the block SHALL write the word, set dirty, and drive dout=din.
REQ-026 COMPARE miss with a clean or invalid victim: the block SHALL go to ALLOCATE.
REQ-027 COMPARE miss with a dirty valid victim: the block SHALL go to WRITE_BACK.
REQ-028 Hit latency SHALL be exactly 1 cycle after acceptance.
REQ-029 Back-to-back hits SHALL complete one every 2 cycles.
REQ-030 In WRITE_BACK, mem_req_valid=1, mem_req_write=1, mem_req_addr={victim tag, index, 4'b0} and mem_req_line=victim data SHALL be held stable until accepted by mem_req_ready=1.
REQ-031 After the WRITE_BACK request is accepted, the block SHALL wait for mem_resp_valid, then clear dirty and go to ALLOCATE.
REQ-032 In ALLOCATE, mem_req_valid=1, mem_req_write=0 and mem_req_addr={req tag, index, 4'b0} SHALL be held stable until accepted.
REQ-033 After the ALLOCATE request is accepted, on mem_resp_valid the block SHALL fill the line with mem_resp_line, set valid=1, dirty=0 and tag, and return to COMPARE.
REQ-034 A retried COMPARE after a fill SHALL always hit, with is_hit=0 on that completion.
REQ-035 mem_req_valid SHALL fall in the cycle after acceptance.
REQ-036 A mem_resp_valid arriving in the same cycle as mem_req_ready SHALL be ignored.
REQ-037 Any mem_resp_valid arriving while no request is outstanding SHALL be ignored.
REQ-038 Requests presented while is_ready=0 SHALL be ignored without side effects.
REQ-039 The block SHALL keep 32-bit counters hit_count and miss_count, incremented on each first-lookup hit and miss respectively, wrapping at 2^32.
REQ-040 hit_count and miss_count SHALL be readable through hierarchy only (no ports).

Reset
REQ-041 While reset=1 at a clock edge, the FSM SHALL enter IDLE and all valid bits, dirty bits and counters SHALL clear.
REQ-042 After reset, is_ready=1, is_output_valid=0, is_hit=0, dout=0 and mem_req_valid=0 SHALL hold from the following cycle.
REQ-043 Reset asserted mid-miss SHALL abandon the transaction, deassert mem_req_valid in the next cycle, and discard any later memory response.
REQ-044 Tag and data arrays need not be reset.

Verification
REQ-045 Cold load addr=0x100: ALLOCATE request addr 0x100; after a response with word1=0xDEADBEEF, load 0x104 -> is_output_valid with dout=0xDEADBEEF and is_hit=1, 1 cycle after acceptance.
REQ-046 Store 0x104 din=0x12345678 hit, then a load to a conflicting address 0x204 (same index, different tag) -> WRITE_BACK to 0x100 with line word1=0x12345678 precedes ALLOCATE to 0x200.
REQ-047 Hold mem_req_ready=0 for 5 cycles -> mem_req_valid, addr and line stay stable; the transfer happens only on the ready edge, and is_ready stays 0 throughout.
REQ-048 Assert reset during the wait in ALLOCATE, then issue a spurious mem_resp_valid -> the block stays IDLE, a subsequent load to the same address misses, and miss_count=1.
REQ-049 Request with mem_read=mem_write=1 -> handled as a store; request with both 0 -> not accepted and the FSM stays IDLE.
REQ-050 Ten hits interleaved with three misses -> hit_count=10 and miss_count=3.
